data_mem_bytelane: RTL and testbench

Parametrised byte-lane data memory for the multi-cycle and pipelined cores. It replaces the fixed 32x32 word-only store with a configurable-depth array. The array supports RISC-V byte, halfword and word loads and stores, with sign or zero extension on loads. A programmable wait-state counter and a req/ready handshake model slow memory. Misaligned, out-of-range and illegal accesses raise a fault instead of corrupting state.

---
 rtl/data_mem_bytelane.sv | 204 ++++++++++++++++++++
 tb/tb_data_mem_bytelane.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory with RISC-V sized loads/stores, a wait-state counter
// and a req/ready handshake; illegal accesses complete with fault and no side effects.

module data_mem_lane #(
   parameter int         DEPTH = 1024,
   parameter int         IDX_W = 10,
   parameter logic [7:0] INIT0 = 8'h00,
   parameter logic [7:0] INIT1 = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       wbyte,
   output logic [7:0]       rbyte
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= (i == 0) ? INIT0 : (i == 1) ? INIT1 : 8'h00;
      end else if (wen) begin
         mem[idx] <= wbyte;
      end
   end

   assign rbyte = mem[idx];
endmodule

module data_mem_bytelane #(
   parameter int          ADDR_W      = 32,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] INIT0       = 32'h0000000F,
   parameter logic [31:0] INIT1       = 32'h0000000A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              fault,
   output logic              busy
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int LANES = 4;

   typedef struct packed {
      logic              we;
      logic [2:0]        funct3;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                 state, state_nxt;
   req_t                   held, cur;
   logic [2:0]             cnt;
   logic                   cur_fault, do_access;
   logic [IDX_W-1:0]       idx;
   logic [LANES-1:0]       lane_we;
   logic [LANES-1:0][7:0]  lane_wd, lane_rd;
   logic [31:0]            word, shifted, load_val;

   // In IDLE the access may complete on the accept edge (WAIT_STATES=0),
   // so decode straight from the ports; afterwards use the latched copy.
   always_comb begin
      if (state == IDLE) begin
         cur.we     = we;
         cur.funct3 = funct3;
         cur.addr   = addr;
         cur.wdata  = wdata;
      end else begin
         cur = held;
      end
   end

   assign idx = cur.addr[IDX_W+1:2];

   // Upper address bits never alias: anything past the array is a fault.
   always_comb begin
      cur_fault = 1'b0;
      if ((cur.addr >> (IDX_W + 2)) != '0)                       cur_fault = 1'b1;
      if (cur.funct3[1:0] == 2'b11 || cur.funct3 == 3'b110)      cur_fault = 1'b1;
      if (cur.funct3[1:0] == 2'b01 && cur.addr[0])               cur_fault = 1'b1;
      if (cur.funct3[1:0] == 2'b10 && cur.addr[1:0] != 2'b00)    cur_fault = 1'b1;
      if (cur.we && cur.funct3[2])                               cur_fault = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      do_access = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (cur_fault) begin
                  state_nxt = RESP;
               end else if (WAIT_STATES == 0) begin
                  do_access = 1'b1;
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 3'd1) begin
               do_access = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Sub-word stores replicate the low data onto every candidate lane; the
   // enable picks which lanes actually take it.
   always_comb begin
      lane_we = '0;
      lane_wd = '0;
      for (int l = 0; l < LANES; l++) begin
         case (cur.funct3[1:0])
            2'b00: begin
               lane_we[l] = (cur.addr[1:0] == 2'(l));
               lane_wd[l] = cur.wdata[7:0];
            end
            2'b01: begin
               lane_we[l] = (cur.addr[1] == (l >= 2));
               lane_wd[l] = cur.wdata[8*(l%2) +: 8];
            end
            default: begin
               lane_we[l] = 1'b1;
               lane_wd[l] = cur.wdata[8*l +: 8];
            end
         endcase
         lane_we[l] = lane_we[l] & do_access & cur.we;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      data_mem_lane #(
         .DEPTH (DEPTH_WORDS),
         .IDX_W (IDX_W),
         .INIT0 (INIT0[8*g +: 8]),
         .INIT1 (INIT1[8*g +: 8])
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .wen   (lane_we[g]),
         .idx   (idx),
         .wbyte (lane_wd[g]),
         .rbyte (lane_rd[g])
      );
   end

   always_comb begin
      word    = lane_rd;
      shifted = word >> {cur.addr[1:0], 3'b000};
      case (cur.funct3)
         3'b000:  load_val = {{24{shifted[7]}},  shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {24'h000000, shifted[7:0]};
         3'b101:  load_val = {16'h0000,   shifted[15:0]};
         default: load_val = word;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held  <= '0;
         cnt   <= '0;
         rdata <= '0;
         ready <= 1'b0;
         fault <= 1'b0;
      end else begin
         ready <= (state_nxt == RESP);
         fault <= (state == IDLE) && req && cur_fault;
         if (state == IDLE && req) begin
            held <= cur;
            cnt  <= 3'(WAIT_STATES);
         end else if (state == WAIT) begin
            cnt  <= cnt - 3'd1;
         end
         if (state == IDLE && req && cur_fault)
            rdata <= '0;
         else if (do_access)
            rdata <= cur.we ? 32'h0 : load_val;
      end
   end

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_data_mem_bytelane.sv
// Bench for data_mem_bytelane: three instances (WAIT_STATES 1/0/7) checked
// against a byte-addressed reference memory.

module tb_data_mem_bytelane;
   localparam int W_OF   [3] = '{1, 0, 7};
   localparam int DEP_OF [3] = '{64, 1024, 16};

   logic        clk;
   logic        rst;
   logic        req [3];
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata [3];
   logic        ready [3];
   logic        fault [3];
   logic        busy  [3];

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mref [3][4096];

   data_mem_bytelane #(.ADDR_W(32), .DEPTH_WORDS(64), .WAIT_STATES(1)) u_dut_w1 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
      .rdata(rdata[0]), .ready(ready[0]), .fault(fault[0]), .busy(busy[0]));
   data_mem_bytelane #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
      .rdata(rdata[1]), .ready(ready[1]), .fault(fault[1]), .busy(busy[1]));
   data_mem_bytelane #(.ADDR_W(32), .DEPTH_WORDS(16), .WAIT_STATES(7)) u_dut_w7 (
      .clk(clk), .rst(rst), .req(req[2]), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
      .rdata(rdata[2]), .ready(ready[2]), .fault(fault[2]), .busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      logic [31:0] i0, i1;
      i0 = 32'h0000000F;
      i1 = 32'h0000000A;
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 4096; i++) mref[d][i] = 8'h00;
         for (int i = 0; i < 4; i++) begin
            mref[d][i]     = i0[8*i +: 8];
            mref[d][4 + i] = i1[8*i +: 8];
         end
      end
   endfunction

   // Byte-addressed view of the architectural rules for one access.
   function automatic void model_access(input int d, input logic w, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd,
                                        output logic flt, output logic [31:0] rd);
      longint unsigned ua, lim, val;
      int  size;
      bit  uns;
      ua = a; lim = 4 * DEP_OF[d]; val = 0; size = 1; uns = 0; flt = 1'b0; rd = '0;
      case (f3)
         3'b000: size = 1;
         3'b001: size = 2;
         3'b010: size = 4;
         3'b100: begin size = 1; uns = 1; end
         3'b101: begin size = 2; uns = 1; end
         default: flt = 1'b1;
      endcase
      if (ua >= lim)        flt = 1'b1;
      if (ua % size != 0)   flt = 1'b1;
      if (w && uns)         flt = 1'b1;
      if (flt) return;
      for (int i = 0; i < size; i++) begin
         if (w) mref[d][ua + i] = wd[8*i +: 8];
         else   val = val | (longint'(mref[d][ua + i]) << (8 * i));
      end
      if (!w) begin
         if (!uns && size < 4 && ((val >> (8*size - 1)) & 1) == 1)
            val = val | (~64'd0 << (8 * size));
         rd = 32'(val);
      end
   endfunction

   // Runs one access on instance d and reports what the DUT did, plus the
   // model's expectation. Latency counts falling edges after the accept edge.
   task automatic xact(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic flt, output bit bsy_ok, output logic [31:0] exp_rd,
                       output logic exp_flt);
      model_access(d, w, f3, a, wd, exp_flt, exp_rd);
      @(negedge clk);
      req[d] = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
      @(posedge clk);
      lat = -1; rd = 'x; flt = 1'bx; bsy_ok = 1'b1;
      for (int k = 1; k <= 12 && lat < 0; k++) begin
         @(negedge clk);
         req[d] = 1'b0;
         if (!busy[d]) bsy_ok = 1'b0;
         if (ready[d]) begin
            lat = k; rd = rdata[d]; flt = fault[d];
         end
      end
      @(negedge clk);
      if (ready[d] || busy[d]) bsy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int d = 0; d < 3; d++) req[d] = 1'b0;
      we = 1'b0; funct3 = 3'b010; addr = '0; wdata = '0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (rdata[d] !== 32'h0 || ready[d] !== 1'b0 || fault[d] !== 1'b0 || busy[d] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset[%0d]: rdata=%h ready=%b fault=%b busy=%b, want all zero",
                     d, rdata[d], ready[d], fault[d], busy[d]);
         end
      end
      req[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_hold: busy=%b ready=%b while rst high, want 0/0", busy[0], ready[0]);
      end
      req[0] = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_basic_load();
      int lat; logic [31:0] rd, erd; logic flt, eflt; bit bok;
      logic [31:0] want [2];
      want[0] = 32'h0000000F; want[1] = 32'h0000000A;
      for (int i = 0; i < 2; i++) begin
         xact(0, 1'b0, 3'b010, 32'(4*i), 32'h0, lat, rd, flt, bok, erd, eflt);
         n_checks++;
         if (rd !== want[i] || flt !== 1'b0 || lat != 2 || !bok) begin
            n_errors++;
            $display("FAIL lw_init%0d: rdata=%h fault=%b lat=%0d busy_ok=%0b, want %h/0/2/1",
                     i, rd, flt, lat, bok, want[i]);
         end
      end
   endtask

   task automatic test_byte_loads();
      int lat; logic [31:0] rd, erd; logic flt, eflt; bit bok;
      logic [31:0] want [4];
      want[0] = 32'h00000001; want[1] = 32'h0000007F; want[2] = 32'hFFFFFFFF; want[3] = 32'hFFFFFF80;
      xact(0, 1'b1, 3'b010, 32'd8, 32'h80FF7F01, lat, rd, flt, bok, erd, eflt);
      n_checks++;
      if (rd !== 32'h0 || flt !== 1'b0 || lat != 2) begin
         n_errors++;
         $display("FAIL sw8: rdata=%h fault=%b lat=%0d, want 0/0/2", rd, flt, lat);
      end
      for (int i = 0; i < 4; i++) begin
         xact(0, 1'b0, 3'b000, 32'(8 + i), 32'h0, lat, rd, flt, bok, erd, eflt);
         n_checks++;
         if (rd !== want[i] || flt !== 1'b0) begin
            n_errors++;
            $display("FAIL lb%0d: rdata=%h fault=%b, want %h/0", 8 + i, rd, flt, want[i]);
         end
      end
      xact(0, 1'b0, 3'b100, 32'd11, 32'h0, lat, rd, flt, bok, erd, eflt);
      n_checks++;
      if (rd !== 32'h00000080 || flt !== 1'b0) begin
         n_errors++;
         $display("FAIL lbu11: rdata=%h fault=%b, want 00000080/0", rd, flt);
      end
   endtask

   task automatic test_store_lanes();
      int lat; logic [31:0] rd, erd; logic flt, eflt; bit bok;
      xact(0, 1'b1, 3'b000, 32'd10, 32'h123456AA, lat, rd, flt, bok, erd, eflt);
      xact(0, 1'b0, 3'b010, 32'd8, 32'h0, lat, rd, flt, bok, erd, eflt);
      n_checks++;
      if (rd !== 32'h80AA7F01) begin
         n_errors++;
         $display("FAIL sb10_lw8: rdata=%h, want 80aa7f01", rd);
      end
      xact(0, 1'b1, 3'b001, 32'd8, 32'hFFFF1234, lat, rd, flt, bok, erd, eflt);
      xact(0, 1'b0, 3'b001, 32'd8, 32'h0, lat, rd, flt, bok, erd, eflt);
      n_checks++;
      if (rd !== 32'h00001234) begin
         n_errors++;
         $display("FAIL sh8_lh8: rdata=%h, want 00001234", rd);
      end
      xact(0, 1'b0, 3'b101, 32'd10, 32'h0, lat, rd, flt, bok, erd, eflt);
      n_checks++;
      if (rd !== 32'h000080AA) begin
         n_errors++;
         $display("FAIL lhu10: rdata=%h, want 000080aa", rd);
      end
   endtask

   task automatic test_faults();
      int lat; logic [31:0] rd, erd; logic flt, eflt; bit bok;
      logic [2:0]  f3s [6];
      logic [31:0] as  [6];
      logic        ws  [6];
      logic [31:0] want [3];
      f3s = '{3'b010, 3'b001, 3'b000, 3'b011, 3'b100, 3'b010};
      as  = '{32'd2, 32'd5, 32'd256, 32'd0, 32'd8, 32'h80000000};
      ws  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      want = '{32'h0000000F, 32'h0000000A, 32'h80AA1234};
      for (int i = 0; i < 6; i++) begin
         xact(0, ws[i], f3s[i], as[i], 32'h55555555, lat, rd, flt, bok, erd, eflt);
         n_checks++;
         if (rd !== 32'h0 || flt !== 1'b1 || lat != 1 || !bok) begin
            n_errors++;
            $display("FAIL fault%0d: rdata=%h fault=%b lat=%0d busy_ok=%0b, want 0/1/1/1",
                     i, rd, flt, lat, bok);
         end
      end
      for (int i = 0; i < 3; i++) begin
         xact(0, 1'b0, 3'b010, 32'(4*i), 32'h0, lat, rd, flt, bok, erd, eflt);
         if (i == 2) xact(0, 1'b0, 3'b010, 32'd8, 32'h0, lat, rd, flt, bok, erd, eflt);
         n_checks++;
         if (rd !== want[i] || flt !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_untouched%0d: rdata=%h fault=%b, want %h/0", i, rd, flt, want[i]);
         end
      end
   endtask

   // req held high across the whole busy window: only one access per
   // WAIT_STATES+2 cycles and nothing queued behind it.
   task automatic test_back_to_back();
      for (int d = 0; d < 3; d++) begin
         int w, n_rdy, t1, t2;
         logic [31:0] r1, r2;
         w = W_OF[d]; n_rdy = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
         @(negedge clk);
         req[d] = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'd0; wdata = '0;
         @(posedge clk);
         for (int k = 1; k <= 2*w + 6; k++) begin
            @(negedge clk);
            addr = 32'd4;
            if (ready[d]) begin
               n_rdy++;
               if (n_rdy == 1) begin t1 = k; r1 = rdata[d]; end
               else if (n_rdy == 2) begin t2 = k; r2 = rdata[d]; end
            end
            if (k == 2*w + 3) req[d] = 1'b0;
         end
         n_checks++;
         if (n_rdy != 2 || t1 != w + 1 || t2 != 2*w + 3 || r1 !== 32'h0000000F || r2 !== 32'h0000000A) begin
            n_errors++;
            $display("FAIL b2b_w%0d: readies=%0d at %0d,%0d data %h,%h; want 2 at %0d,%0d data 0000000f,0000000a",
                     w, n_rdy, t1, t2, r1, r2, w + 1, 2*w + 3);
         end
      end
   endtask

   task automatic test_random();
      int lat, r, nlat;
      logic [31:0] rd, erd, a, last_a;
      logic flt, eflt, w;
      logic [2:0] f3;
      bit bok;
      logic [2:0] legal [5];
      legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int d = 0; d < 3; d++) begin
         last_a = '0;
         for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)     a = $urandom();
            else if (r < 4) a = last_a;
            else            a = 32'($urandom_range(0, 4*DEP_OF[d] + 3));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            r = $urandom_range(0, 5);
            f3 = (r == 5) ? 3'($urandom_range(0, 7)) : legal[r];
            w = 1'($urandom_range(0, 1));
            xact(d, w, f3, a, $urandom(), lat, rd, flt, bok, erd, eflt);
            last_a = a;
            nlat = eflt ? 1 : W_OF[d] + 1;
            n_checks++;
            if (rd !== erd || flt !== eflt || lat != nlat || !bok) begin
               n_errors++;
               $display("FAIL rand_w%0d_%0d: we=%b f3=%b addr=%h got rdata=%h fault=%b lat=%0d busy_ok=%0b, want %h/%b/%0d/1",
                        W_OF[d], n, w, f3, a, rd, flt, lat, bok, erd, eflt, nlat);
            end
         end
      end
   endtask

   task automatic test_reset_midwait();
      int lat; logic [31:0] rd, erd; logic flt, eflt; bit bok;
      xact(0, 1'b0, 3'b010, 32'd0, 32'h0, lat, rd, flt, bok, erd, eflt);
      @(negedge clk);
      req[0] = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'd12; wdata = 32'hDEADBEEF;
      @(posedge clk);
      #2;
      n_checks++;
      if (busy[0] !== 1'b1 || rdata[0] !== 32'h0000000F) begin
         n_errors++;
         $display("FAIL midwait_pre: busy=%b rdata=%h, want 1/0000000f", busy[0], rdata[0]);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (rdata[0] !== 32'h0 || ready[0] !== 1'b0 || fault[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL midwait_rst: rdata=%h ready=%b fault=%b busy=%b, want all zero",
                  rdata[0], ready[0], fault[0], busy[0]);
      end
      @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      xact(0, 1'b0, 3'b010, 32'd12, 32'h0, lat, rd, flt, bok, erd, eflt);
      n_checks++;
      if (rd !== 32'h0 || flt !== 1'b0) begin
         n_errors++;
         $display("FAIL midwait_lw12: rdata=%h fault=%b, want 00000000/0", rd, flt);
      end
      xact(0, 1'b0, 3'b010, 32'd0, 32'h0, lat, rd, flt, bok, erd, eflt);
      n_checks++;
      if (rd !== 32'h0000000F || flt !== 1'b0) begin
         n_errors++;
         $display("FAIL midwait_lw0: rdata=%h fault=%b, want 0000000f/0", rd, flt);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_byte_loads();
      test_store_lanes();
      test_faults();
      test_back_to_back();
      test_random();
      test_reset_midwait();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
